// File: rtl/spec_load_fence.sv
// spec_load_fence: speculative-load fence. Tracks unresolved branch tags and
// holds back loads that depend on (or, in STRICT mode, coexist with) any
// pending branch. Optional blocked-load watchdog is compiled in with the
// macro SPEC_LOAD_FENCE_TIMEOUT_EN; without it timeout_o is tied low.
module spec_load_fence #(
  parameter int unsigned NUM_BR  = 8,
  parameter int unsigned STRICT  = 0,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned TAG_W  = $clog2(NUM_BR),
  localparam int unsigned CNT_W  = TAG_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_alloc_i,
  input  logic [TAG_W-1:0]  br_alloc_tag_i,
  input  logic              br_resolve_i,
  input  logic [TAG_W-1:0]  br_resolve_tag_i,
  input  logic              flush_i,
  input  logic              ld_req_i,
  input  logic [NUM_BR-1:0] ld_dep_mask_i,
  output logic              ld_grant_o,
  output logic [NUM_BR-1:0] pending_o,
  output logic [CNT_W-1:0]  pending_cnt_o,
  output logic              full_o,
  output logic              err_o,
  output logic              timeout_o
);

  logic [NUM_BR-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              same_tag_c;
  logic              blocked_c;

  assign same_tag_c = br_alloc_i && br_resolve_i && (br_alloc_tag_i == br_resolve_tag_i);

  // Pending-vector update with protocol error detection; flush wins over everything.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (flush_i) begin
      pending_d = '0;
      err_d     = 1'b0;
    end else begin
      if (br_resolve_i && !same_tag_c) begin
        if (pending_q[br_resolve_tag_i]) begin
          pending_d[br_resolve_tag_i] = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      if (br_alloc_i) begin
        if (pending_q[br_alloc_tag_i] && !same_tag_c) begin
          err_d = 1'b1;
        end
        pending_d[br_alloc_tag_i] = 1'b1;
      end
    end
  end

  // Count and full flag derived from next pending so they update on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_BR; i++) begin
      cnt_d = cnt_d + CNT_W'(pending_d[i]);
    end
    full_d = &pending_d;
  end

  // Tracking state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  // Load gate from registered pending; reset forces it closed.
  always_comb begin
    if (STRICT != 0) begin
      blocked_c = |pending_q;
    end else begin
      blocked_c = |(ld_dep_mask_i & pending_q);
    end
  end

  assign ld_grant_o    = rst_n && ld_req_i && !blocked_c;
  assign pending_o     = pending_q;
  assign pending_cnt_o = cnt_q;
  assign full_o        = full_q;
  assign err_o         = err_q;

`ifdef SPEC_LOAD_FENCE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  // Saturating count of consecutive blocked-request cycles; sticky timeout flag.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (flush_i) begin
      wait_cnt_d = '0;
      timeout_d  = 1'b0;
    end else if (ld_req_i && !ld_grant_o) begin
      if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_spec_load_fence.sv
// Bench for spec_load_fence: directed scenarios plus randomized traffic
// against a tag-set reference model. Two instances: STRICT=0 and STRICT=1.
module tb_spec_load_fence;

  localparam int NB = 8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       br_alloc, br_resolve, flush, ld_req;
  logic [2:0] alloc_tag, resolve_tag;
  logic [7:0] dep_mask;

  logic       g0, g1, f0, f1, e0, e1, t0, t1;
  logic [7:0] p0, p1;
  logic [3:0] c0, c1;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_pend[NB];
  bit m_err;
  int m_wait[2];
  bit m_tmo[2];

  always #5 clk = ~clk;

  spec_load_fence #(.NUM_BR(NB), .STRICT(0), .TIMEOUT(TO)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .br_alloc_i(br_alloc), .br_alloc_tag_i(alloc_tag),
    .br_resolve_i(br_resolve), .br_resolve_tag_i(resolve_tag),
    .flush_i(flush), .ld_req_i(ld_req), .ld_dep_mask_i(dep_mask),
    .ld_grant_o(g0), .pending_o(p0), .pending_cnt_o(c0),
    .full_o(f0), .err_o(e0), .timeout_o(t0));

  spec_load_fence #(.NUM_BR(NB), .STRICT(1), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .br_alloc_i(br_alloc), .br_alloc_tag_i(alloc_tag),
    .br_resolve_i(br_resolve), .br_resolve_tag_i(resolve_tag),
    .flush_i(flush), .ld_req_i(ld_req), .ld_dep_mask_i(dep_mask),
    .ld_grant_o(g1), .pending_o(p1), .pending_cnt_o(c1),
    .full_o(f1), .err_o(e1), .timeout_o(t1));

  function automatic bit m_grant(int strict);
    if (!rst_n || !ld_req) return 1'b0;
    for (int i = 0; i < NB; i++)
      if (m_pend[i] && (strict != 0 || dep_mask[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_vec();
    logic [7:0] v;
    for (int i = 0; i < NB; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NB; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic bit m_timeout(int k);
`ifdef SPEC_LOAD_FENCE_TIMEOUT_EN
    return m_tmo[k];
`else
    return 1'b0 & m_tmo[k];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_pend[i] = 1'b0;
    m_err = 1'b0;
    for (int k = 0; k < 2; k++) begin m_wait[k] = 0; m_tmo[k] = 1'b0; end
  endtask

  task automatic set_in(input bit a, input int at, input bit r, input int rt,
                        input bit fl, input bit rq, input logic [7:0] mk);
    br_alloc = a; alloc_tag = 3'(at);
    br_resolve = r; resolve_tag = 3'(rt);
    flush = fl; ld_req = rq; dep_mask = mk;
  endtask

  // advance one clock and apply the behavioural rules to the model
  task automatic tick();
    bit g[2];
    bit old[NB];
    g[0] = m_grant(0);
    g[1] = m_grant(1);
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      old = m_pend;
      if (br_alloc && br_resolve && alloc_tag == resolve_tag) begin
        m_pend[alloc_tag] = 1'b1;
      end else begin
        if (br_resolve) begin
          if (old[resolve_tag]) m_pend[resolve_tag] = 1'b0;
          else m_err = 1'b1;
        end
        if (br_alloc) begin
          if (old[alloc_tag]) m_err = 1'b1;
          m_pend[alloc_tag] = 1'b1;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (ld_req && !g[k]) begin
          if (m_wait[k] < TO) m_wait[k]++;
          if (m_wait[k] == TO) m_tmo[k] = 1'b1;
        end else begin
          m_wait[k] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 8'h00);
    model_reset();
    #2;
    checks++; if (g0 !== 1'b0 || g1 !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b/%b want 0/0", g0, g1); end
    checks++; if (p0 !== 8'h00 || c0 !== 4'd0) begin errors++; $display("FAIL reset_pending: got %h cnt %0d want 00 cnt 0", p0, c0); end
    checks++; if (f0 !== 1'b0 || e0 !== 1'b0 || t0 !== 1'b0) begin errors++; $display("FAIL reset_flags: got full %b err %b tmo %b want 000", f0, e0, t0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic test_mask_grant();
    set_in(1, 3, 0, 0, 0, 0, 8'h00); tick();
    set_in(0, 0, 0, 0, 0, 1, 8'h08); #1;
    checks++; if (g0 !== 1'b0) begin errors++; $display("FAIL mask08_grant: got %b want 0", g0); end
    dep_mask = 8'h04; #1;
    checks++; if (g0 !== 1'b1) begin errors++; $display("FAIL mask04_grant: got %b want 1", g0); end
    checks++; if (g1 !== 1'b0) begin errors++; $display("FAIL strict_mask04_grant: got %b want 0", g1); end
    checks++; if (p0 !== 8'h08 || c0 !== 4'd1) begin errors++; $display("FAIL alloc3_pending: got %h cnt %0d want 08 cnt 1", p0, c0); end
  endtask

  task automatic test_resolve_latency();
    set_in(0, 0, 1, 3, 0, 1, 8'h08); #1;
    checks++; if (g0 !== 1'b0) begin errors++; $display("FAIL resolve_cycle_grant: got %b want 0", g0); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 8'h08); #1;
    checks++; if (g0 !== 1'b1) begin errors++; $display("FAIL resolve_next_grant: got %b want 1", g0); end
    checks++; if (c0 !== 4'd0 || p0 !== 8'h00) begin errors++; $display("FAIL resolve_count: got %h cnt %0d want 00 cnt 0", p0, c0); end
    set_in(0, 0, 0, 0, 0, 0, 8'h00); tick();
  endtask

  task automatic test_full_and_err();
    for (int t = 0; t < NB; t++) begin set_in(1, t, 0, 0, 0, 0, 8'h00); tick(); end
    checks++; if (f0 !== 1'b1 || c0 !== 4'd8 || p0 !== 8'hff) begin errors++; $display("FAIL full: got full %b cnt %0d pend %h want 1 8 ff", f0, c0, p0); end
    checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL full_no_err: got %b want 0", e0); end
    set_in(1, 2, 0, 0, 0, 0, 8'h00); tick();
    checks++; if (e0 !== 1'b1 || e1 !== 1'b1) begin errors++; $display("FAIL realloc_err: got %b/%b want 1/1", e0, e1); end
    checks++; if (p0 !== 8'hff || c0 !== 4'd8) begin errors++; $display("FAIL realloc_pending: got %h cnt %0d want ff 8", p0, c0); end
    set_in(0, 0, 0, 0, 0, 0, 8'h00); tick();
    checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", e0); end
  endtask

  task automatic test_same_cycle_and_flush();
    set_in(0, 0, 0, 0, 1, 0, 8'h00); tick();
    checks++; if (p0 !== 8'h00 || e0 !== 1'b0 || f0 !== 1'b0) begin errors++; $display("FAIL flush_clear: got %h err %b full %b want 00 0 0", p0, e0, f0); end
    set_in(1, 5, 0, 0, 0, 0, 8'h00); tick();
    set_in(1, 5, 1, 5, 0, 0, 8'h00); tick();
    checks++; if (p0 !== 8'h20 || e0 !== 1'b0) begin errors++; $display("FAIL same_tag: got %h err %b want 20 0", p0, e0); end
    set_in(0, 0, 1, 7, 0, 0, 8'h00); tick();
    checks++; if (p0 !== 8'h20 || e0 !== 1'b1) begin errors++; $display("FAIL bad_resolve: got %h err %b want 20 1", p0, e0); end
    set_in(1, 1, 1, 4, 1, 0, 8'h00); tick();
    checks++; if (p0 !== 8'h00 || c0 !== 4'd0 || e0 !== 1'b0) begin errors++; $display("FAIL flush_alloc: got %h cnt %0d err %b want 00 0 0", p0, c0, e0); end
  endtask

  task automatic test_strict();
    set_in(1, 6, 0, 0, 0, 0, 8'h00); tick();
    set_in(0, 0, 0, 0, 0, 1, 8'h00); #1;
    checks++; if (g1 !== 1'b0) begin errors++; $display("FAIL strict_block: got %b want 0", g1); end
    checks++; if (g0 !== 1'b1) begin errors++; $display("FAIL nonstrict_pass: got %b want 1", g0); end
    ld_req = 1'b0; #1;
    checks++; if (g0 !== 1'b0) begin errors++; $display("FAIL no_req_grant: got %b want 0", g0); end
  endtask

  task automatic test_timeout();
    bit exp_t;
`ifdef SPEC_LOAD_FENCE_TIMEOUT_EN
    exp_t = 1'b1;
`else
    exp_t = 1'b0;
`endif
    set_in(0, 0, 0, 0, 1, 0, 8'h00); tick();
    set_in(1, 0, 0, 0, 0, 0, 8'h00); tick();
    set_in(0, 0, 0, 0, 0, 1, 8'h01);
    repeat (3) tick();
    checks++; if (t0 !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", t0); end
    tick();
    checks++; if (t0 !== exp_t || t1 !== exp_t) begin errors++; $display("FAIL timeout_hit: got %b/%b want %b", t0, t1, exp_t); end
    tick();
    checks++; if (t0 !== exp_t) begin errors++; $display("FAIL timeout_sticky: got %b want %b", t0, exp_t); end
    set_in(0, 0, 0, 0, 1, 1, 8'h01); tick();
    checks++; if (t0 !== 1'b0 || t1 !== 1'b0) begin errors++; $display("FAIL timeout_flush: got %b/%b want 0/0", t0, t1); end
    set_in(0, 0, 0, 0, 0, 0, 8'h00); tick();
  endtask

  task automatic test_random();
    int pend_list[$];
    int rt;
    for (int n = 0; n < 400; n++) begin
      pend_list.delete();
      for (int i = 0; i < NB; i++) if (m_pend[i]) pend_list.push_back(i);
      rt = int'($urandom_range(NB - 1));
      if (pend_list.size() > 0 && ($urandom % 4) != 0)
        rt = pend_list[$urandom % pend_list.size()];
      set_in(1'($urandom % 2), int'($urandom_range(NB - 1)), 1'($urandom % 2), rt,
             ($urandom % 40) == 0, 1'($urandom % 2), 8'($urandom & $urandom));
      #1;
      checks++; if (g0 !== m_grant(0) || g1 !== m_grant(1)) begin errors++; $display("FAIL rnd_grant[%0d]: got %b/%b want %b/%b", n, g0, g1, m_grant(0), m_grant(1)); end
      tick();
      checks++; if (p0 !== m_vec() || p1 !== m_vec()) begin errors++; $display("FAIL rnd_pending[%0d]: got %h/%h want %h", n, p0, p1, m_vec()); end
      checks++; if (int'(c0) != m_count() || f0 !== (m_count() == NB)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d full %b want %0d", n, c0, f0, m_count()); end
      checks++; if (e0 !== m_err || e1 !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b/%b want %b", n, e0, e1, m_err); end
      checks++; if (t0 !== m_timeout(0) || t1 !== m_timeout(1)) begin errors++; $display("FAIL rnd_timeout[%0d]: got %b/%b want %b/%b", n, t0, t1, m_timeout(0), m_timeout(1)); end
    end
    set_in(0, 0, 0, 0, 0, 0, 8'h00); tick();
  endtask

  task automatic test_reset_mid();
    set_in(1, 2, 0, 0, 0, 0, 8'h00); tick();
    set_in(0, 0, 0, 0, 0, 1, 8'h00);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (p0 !== 8'h00 || c0 !== 4'd0 || g0 !== 1'b0) begin errors++; $display("FAIL midreset: got %h cnt %0d grant %b want 00 0 0", p0, c0, g0); end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 4, 0, 0, 0, 0, 8'h00); tick();
    checks++; if (p0 !== 8'h10 || c0 !== 4'd1) begin errors++; $display("FAIL post_reset_alloc: got %h cnt %0d want 10 1", p0, c0); end
  endtask

  initial begin
    test_reset();
    test_mask_grant();
    test_resolve_latency();
    test_full_and_err();
    test_same_cycle_and_flush();
    test_strict();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
